// File: rtl/uio_bus_arbiter_pkg.sv
// Shared types and constants for the uio pad-bus arbiter.
// Holds the FSM state encoding, direction values and pad-enable patterns.
package uio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        XFER = 2'd2
    } state_t;

    localparam logic       DIR_IN  = 1'b0;
    localparam logic       DIR_OUT = 1'b1;

    localparam logic [7:0] OE_ON   = 8'hFF;
    localparam logic [7:0] OE_OFF  = 8'h00;

    // Pad enable for a given bus direction and state: the pads are driven
    // whenever the bus faces outward, except during the turnaround cycle.
    function automatic logic [7:0] oe_decode(input logic dir_out, input state_t st);
        logic [7:0] oe_v;
        if ((dir_out == DIR_OUT) && (st != TURN)) begin
            oe_v = OE_ON;
        end else begin
            oe_v = OE_OFF;
        end
        return oe_v;
    endfunction

endpackage

// File: rtl/uio_bus_arbiter_if.sv
// Bundle of requester-side and pad-side signals around the uio arbiter.
// The arbiter uses the slave view; the requesters/pads use the master view.
interface uio_bus_arbiter_if #(
    parameter int NREQ = 4
) ();

    logic                  ena;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       dir;
    logic [8*NREQ-1:0]     wdata;
    logic [7:0]            uio_in;

    logic [NREQ-1:0]       gnt;
    logic                  rd_valid;
    logic [7:0]            rd_data;
    logic [7:0]            uio_out;
    logic [7:0]            uio_oe;
    logic                  busy;

    modport slave (
        input  ena,
        input  req,
        input  dir,
        input  wdata,
        input  uio_in,
        output gnt,
        output rd_valid,
        output rd_data,
        output uio_out,
        output uio_oe,
        output busy
    );

    modport master (
        output ena,
        output req,
        output dir,
        output wdata,
        output uio_in,
        input  gnt,
        input  rd_valid,
        input  rd_data,
        input  uio_out,
        input  uio_oe,
        input  busy
    );

endinterface

// File: rtl/uio_bus_arbiter_rr_pick.sv
// Round-robin selector: returns the first requesting index after `last`,
// wrapping modulo NREQ, and whether any request is present at all.
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [IW-1:0]   pick,
    output logic            any
);

    logic [IW-1:0] idx_s;

    // Scan candidates from farthest to nearest so the nearest hit after `last` wins.
    always_comb begin
        pick  = last;
        any   = 1'b0;
        idx_s = last;
        for (int k = NREQ; k >= 1; k--) begin
            idx_s = IW'((int'(last) + k) % NREQ);
            pick  = req[idx_s] ? idx_s : pick;
            any   = any | req[idx_s];
        end
    end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the shared 8-bit uio pad bus.
// Grants one requester at a time, inserts a one-cycle turnaround on every
// direction change and caps each grant at HOLD_MAX beats. All outputs come
// straight from flops; no input reaches an output combinationally.
module uio_bus_arbiter
    import uio_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    uio_bus_arbiter_if.slave bus
);

    localparam int            IW        = $clog2(NREQ);
    localparam logic [7:0]    LAST_BEAT = 8'(HOLD_MAX - 1);
    localparam logic [IW-1:0] LAST_INIT = IW'(NREQ - 1);

    // Control state
    state_t          state_r,    state_s;
    logic [IW-1:0]   owner_r,    owner_s;
    logic [IW-1:0]   last_r,     last_s;
    logic            cur_dir_r,  cur_dir_s;
    logic [7:0]      beats_r,    beats_s;

    // Output registers
    logic [7:0]      uio_out_r,  uio_out_s;
    logic [7:0]      rd_data_r,  rd_data_s;
    logic            rd_valid_r, rd_valid_s;
    logic [NREQ-1:0] gnt_r,      gnt_s;
    logic [7:0]      oe_r,       oe_s;
    logic            busy_r,     busy_s;

    // Helpers
    logic [IW-1:0]   pick_s;
    logic            any_s;
    logic            owner_req_s;
    logic [7:0]      wbyte_s;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req  (bus.req),
        .last (last_r),
        .pick (pick_s),
        .any  (any_s)
    );

    assign owner_req_s = bus.req[owner_r];
    assign wbyte_s     = bus.wdata[int'(owner_r) * 8 +: 8];

    // Next-state, beat counting and pad data capture.
    always_comb begin
        state_s    = state_r;
        owner_s    = owner_r;
        last_s     = last_r;
        cur_dir_s  = cur_dir_r;
        beats_s    = beats_r;
        uio_out_s  = uio_out_r;
        rd_data_s  = rd_data_r;
        rd_valid_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.ena && any_s) begin
                    owner_s = pick_s;
                    last_s  = pick_s;
                    beats_s = 8'd0;
                    if (bus.dir[pick_s] != cur_dir_r) begin
                        state_s = TURN;
                    end else begin
                        state_s = XFER;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            TURN: begin
                // TURN is only entered when the picked direction differs from
                // the bus, so flipping reuses the direction seen at pick time.
                cur_dir_s = ~cur_dir_r;
                state_s   = XFER;
            end
            XFER: begin
                if (!owner_req_s) begin
                    state_s = IDLE;
                end else begin
                    beats_s = beats_r + 8'd1;
                    if (cur_dir_r == DIR_OUT) begin
                        uio_out_s = wbyte_s;
                    end else begin
                        rd_data_s  = bus.uio_in;
                        rd_valid_s = 1'b1;
                    end
                    if (beats_r == LAST_BEAT) begin
                        state_s = IDLE;
                    end else begin
                        state_s = XFER;
                    end
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Decode grant, pad enable and busy from the upcoming state so they can be registered.
    always_comb begin
        gnt_s = {NREQ{1'b0}};
        if (state_s == XFER) begin
            gnt_s[owner_s] = 1'b1;
        end else begin
            gnt_s = {NREQ{1'b0}};
        end
        oe_s   = oe_decode(cur_dir_s, state_s);
        busy_s = (state_s != IDLE);
    end

    // FSM and arbitration bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            owner_r   <= {IW{1'b0}};
            last_r    <= LAST_INIT;
            cur_dir_r <= DIR_IN;
            beats_r   <= 8'd0;
        end else begin
            state_r   <= state_s;
            owner_r   <= owner_s;
            last_r    <= last_s;
            cur_dir_r <= cur_dir_s;
            beats_r   <= beats_s;
        end
    end

    // Registered outputs towards the pads and the requesters.
    always_ff @(posedge clk) begin
        if (rst) begin
            uio_out_r  <= 8'h00;
            rd_data_r  <= 8'h00;
            rd_valid_r <= 1'b0;
            gnt_r      <= {NREQ{1'b0}};
            oe_r       <= OE_OFF;
            busy_r     <= 1'b0;
        end else begin
            uio_out_r  <= uio_out_s;
            rd_data_r  <= rd_data_s;
            rd_valid_r <= rd_valid_s;
            gnt_r      <= gnt_s;
            oe_r       <= oe_s;
            busy_r     <= busy_s;
        end
    end

    assign bus.gnt      = gnt_r;
    assign bus.rd_valid = rd_valid_r;
    assign bus.rd_data  = rd_data_r;
    assign bus.uio_out  = uio_out_r;
    assign bus.uio_oe   = oe_r;
    assign bus.busy     = busy_r;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Scoreboard bench for uio_bus_arbiter (NREQ=4, HOLD_MAX=3).
// Expected grants and read bytes are queued as stimulus is driven and popped
// by a negedge monitor; cycle-exact pad/grant values are checked inline.
module tb_uio_bus_arbiter;

    localparam int NREQ     = 4;
    localparam int HOLD_MAX = 3;

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]      rd_q[$];
    logic [NREQ-1:0] gnt_q[$];
    logic [NREQ-1:0] prev_gnt;
    logic [7:0]      v8;

    uio_bus_arbiter_if #(.NREQ(NREQ)) bus ();

    uio_bus_arbiter #(
        .NREQ     (NREQ),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctl(input string tag, input logic [3:0] g, input logic [7:0] oe, input logic b);
        check_eq({tag, "_gnt"},  32'(bus.gnt),    32'(g));
        check_eq({tag, "_oe"},   32'(bus.uio_oe), 32'(oe));
        check_eq({tag, "_busy"}, 32'(bus.busy),   32'(b));
    endtask

    // Monitor: new grants and read beats are compared against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rd_valid) begin
                if (rd_q.size() > 0) begin
                    check_eq("rd_data", 32'(bus.rd_data), 32'(rd_q.pop_front()));
                end else begin
                    check_eq("rd_valid_unexpected", 32'(bus.rd_valid), 32'h0);
                end
            end
            if ((prev_gnt == 4'b0000) && (bus.gnt != 4'b0000)) begin
                if (gnt_q.size() > 0) begin
                    check_eq("grant_order", 32'(bus.gnt), 32'(gnt_q.pop_front()));
                end else begin
                    check_eq("grant_unexpected", 32'(bus.gnt), 32'h0);
                end
            end
        end
        prev_gnt <= bus.gnt;
    end

    initial begin
        rst        = 1'b1;
        bus.ena    = 1'b1;
        bus.req    = 4'b0000;
        bus.dir    = 4'b0000;
        bus.wdata  = 32'h0;
        bus.uio_in = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check_ctl("rst", 4'b0000, 8'h00, 1'b0);
        check_eq("rst_uio_out",  32'(bus.uio_out),  32'h0);
        check_eq("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
        check_eq("rst_rd_data",  32'(bus.rd_data),  32'h0);

        // Requester 0 reads: same direction as reset, one-cycle grant latency
        bus.req = 4'b0001;
        gnt_q.push_back(4'b0001);
        tick();
        check_ctl("t1", 4'b0001, 8'h00, 1'b1);
        bus.req = 4'b0000;
        tick();
        check_ctl("t1_end", 4'b0000, 8'h00, 1'b0);

        // Requester 1 writes: turnaround, then three beats (third hits HOLD_MAX)
        bus.req = 4'b0010;
        bus.dir = 4'b0010;
        gnt_q.push_back(4'b0010);
        tick();
        check_ctl("t2_turn", 4'b0000, 8'h00, 1'b1);
        tick();
        check_ctl("t2_xfer", 4'b0010, 8'hFF, 1'b1);
        check_eq("t2_pre_out", 32'(bus.uio_out), 32'h0);
        bus.wdata[15:8] = 8'hA5;
        tick();
        check_eq("t2_out0", 32'(bus.uio_out), 32'hA5);
        check_eq("t2_gnt0", 32'(bus.gnt), 32'h2);
        bus.wdata[15:8] = 8'h5A;
        tick();
        check_eq("t2_out1", 32'(bus.uio_out), 32'h5A);
        bus.wdata[15:8] = 8'hC3;
        tick();
        check_eq("t2_out2", 32'(bus.uio_out), 32'hC3);
        check_ctl("t2_hold", 4'b0000, 8'hFF, 1'b0);
        bus.req = 4'b0000;
        tick();
        check_ctl("t2_idle", 4'b0000, 8'hFF, 1'b0);

        // Requester 2 reads: turnaround back to input, three read beats
        bus.req = 4'b0100;
        bus.dir = 4'b0000;
        gnt_q.push_back(4'b0100);
        tick();
        check_ctl("t3_turn", 4'b0000, 8'h00, 1'b1);
        tick();
        check_ctl("t3_xfer", 4'b0100, 8'h00, 1'b1);
        for (int b = 0; b < 3; b++) begin
            v8 = 8'(17 * (b + 1));
            bus.uio_in = v8;
            rd_q.push_back(v8);
            tick();
            check_eq("t3_rd_valid", 32'(bus.rd_valid), 32'h1);
            check_eq("t3_rd_data",  32'(bus.rd_data),  32'(v8));
        end
        bus.req = 4'b0000;
        tick();
        check_eq("t3_rd_pulse_end", 32'(bus.rd_valid), 32'h0);
        check_eq("t3_rd_hold",      32'(bus.rd_data),  32'h33);

        // Rotation with all requesters held: 3,0,1,2,3 (last grant was 2)
        bus.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            int idx;
            idx = (3 + g) % 4;
            gnt_q.push_back(4'(1 << idx));
            tick();
            check_eq("rot_gnt", 32'(bus.gnt), 32'(1 << idx));
            for (int b = 0; b < 3; b++) begin
                v8 = 8'(16 * g + b + 1);
                bus.uio_in = v8;
                rd_q.push_back(v8);
                tick();
                if (b < 2) begin
                    check_eq("rot_gnt_hold", 32'(bus.gnt), 32'(1 << idx));
                end else begin
                    check_eq("rot_gap", 32'(bus.gnt), 32'h0);
                end
            end
        end
        bus.req = 4'b0000;
        tick();
        check_ctl("rot_end", 4'b0000, 8'h00, 1'b0);

        // Request drops on the edge that would complete HOLD_MAX: no beat
        bus.req = 4'b0001;
        gnt_q.push_back(4'b0001);
        tick();
        check_eq("t5_gnt", 32'(bus.gnt), 32'h1);
        bus.uio_in = 8'h77; rd_q.push_back(8'h77); tick();
        bus.uio_in = 8'h88; rd_q.push_back(8'h88); tick();
        check_eq("t5_gnt_hold", 32'(bus.gnt), 32'h1);
        bus.req    = 4'b0000;
        bus.uio_in = 8'h99;
        tick();
        check_ctl("t5_drop", 4'b0000, 8'h00, 1'b0);
        check_eq("t5_no_beat", 32'(bus.rd_valid), 32'h0);
        // Re-grant gets a fresh beat budget
        bus.req = 4'b0001;
        gnt_q.push_back(4'b0001);
        tick();
        check_eq("t5_regnt", 32'(bus.gnt), 32'h1);
        for (int b = 0; b < 3; b++) begin
            v8 = 8'(8'hE0 + b);
            bus.uio_in = v8;
            rd_q.push_back(v8);
            tick();
        end
        check_eq("t5_cap", 32'(bus.gnt), 32'h0);
        bus.req = 4'b0000;
        tick();

        // Enable gating: no grant while ena is low
        bus.ena = 1'b0;
        bus.req = 4'b1000;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_ctl("t6_blocked", 4'b0000, 8'h00, 1'b0);
        end
        bus.ena = 1'b1;
        gnt_q.push_back(4'b1000);
        tick();
        check_ctl("t6_gnt", 4'b1000, 8'h00, 1'b1);
        // Direction toggle and ena drop mid-burst: burst continues as reads
        bus.dir = 4'b1000;
        bus.ena = 1'b0;
        for (int b = 0; b < 3; b++) begin
            v8 = 8'(8'h9A + b);
            bus.uio_in = v8;
            rd_q.push_back(v8);
            tick();
            check_eq("t6_oe_hold", 32'(bus.uio_oe), 32'h00);
        end
        check_eq("t6_burst_done", 32'(bus.gnt), 32'h0);
        tick();
        check_ctl("t6_ena_low", 4'b0000, 8'h00, 1'b0);
        bus.req = 4'b0000;

        // Write burst by requester 1, reset asserted mid-burst
        bus.ena         = 1'b1;
        bus.req         = 4'b0010;
        bus.dir         = 4'b0010;
        bus.wdata[15:8] = 8'hE7;
        gnt_q.push_back(4'b0010);
        tick();
        check_ctl("t7_turn", 4'b0000, 8'h00, 1'b1);
        tick();
        check_ctl("t7_xfer", 4'b0010, 8'hFF, 1'b1);
        tick();
        check_eq("t7_out", 32'(bus.uio_out), 32'hE7);
        rst = 1'b1;
        tick();
        check_ctl("t7_rst", 4'b0000, 8'h00, 1'b0);
        check_eq("t7_rst_out", 32'(bus.uio_out), 32'h00);
        // After reset requester 0 wins even with everyone requesting
        rst     = 1'b0;
        bus.req = 4'b1111;
        bus.dir = 4'b0000;
        gnt_q.push_back(4'b0001);
        tick();
        check_ctl("t7_first", 4'b0001, 8'h00, 1'b1);
        bus.req = 4'b0000;
        tick();
        check_eq("t7_end", 32'(bus.gnt), 32'h0);
        tick();

        check_eq("gnt_queue_drained", 32'(gnt_q.size()), 32'h0);
        check_eq("rd_queue_drained",  32'(rd_q.size()),  32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
